msg_ram_writer: RTL
===================

Name: msg_ram_writer

Overview:
- Write-side counterpart of the scrolling-message display reader.
- Accepts 14-bit glyph-column words over a valid/ready stream and stores them in consecutive SRAM locations.
- Selects one of three SRAM banks by address bits [11:10]; bank 00 is ROM and is never written.
- Lets the display path scroll a runtime-loaded message instead of the fixed ROM text.

Parameters:
- WORD_W, 14, payload width per word, stored zero-extended into a 16-bit SRAM word.
- MAX_WORDS, 6, maximum message length in words; the display packs 6 words into one frame.
- ADDR_W, 12, full address width: bits [11:10] select the bank, bits [9:0] are the offset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- base_addr  in  12  first address of the message; [11:10] must be 01, 10 or 11.
- word_cnt  in  3  number of words to load, 1..MAX_WORDS; sampled at start.
- in_data  in  14  payload word.
- in_valid  in  1  payload valid.
- in_ready  out  1  writer can accept in_data this cycle.
- address  out  10  SRAM offset.
- data_in  out  16  SRAM write data, {2'b00, word}.
- cs_ram  out  3  one-hot bank select: bit0 = bank 01, bit1 = bank 10, bit2 = bank 11.
- wr  out  1  SRAM read/write strobe: 0 = write, 1 = read (idle level).
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when the last word has been written.
- err  out  1  sticky until next start; load rejected, or verify mismatch.

Behaviour:
- Reset values: in_ready=0, address=0, data_in=0, cs_ram=000, wr=1, busy=0, done=0, err=0. FSM goes to IDLE and the counters clear.
- IDLE:
  - start with base_addr[11:10]==00, or word_cnt==0, or word_cnt>MAX_WORDS: set err=1, stay in IDLE, perform no SRAM access.
  - Valid start: latch the bank and offset, latch the count, clear err, set busy=1, go to ACCEPT.
- ACCEPT:
  - in_ready=1, cs_ram=000, wr=1.
  - When in_valid && in_ready, latch the word and go to WRITE.
- WRITE (exactly one cycle):
  - cs_ram = one-hot bank, wr=0, address = current offset, data_in = {2'b00, word}.
  - in_ready=0.
  - Next state: VERIFY if VERIFY_EN is defined, otherwise ADV.
- ADV:
  - Deassert cs_ram and set wr=1.
  - Increment the offset modulo 1024; wrap 1023→0 stays in the same bank and never carries into [11:10].
  - Decrement the remaining count.
  - Remaining==0: pulse done=1, busy=0, go to IDLE. Otherwise go to ACCEPT.
- Throughput: best case one word per 3 cycles (ACCEPT, WRITE, ADV); 4 cycles with verify.
- Handshake:
  - in_ready is a registered output.
  - A word is consumed only on a cycle where in_valid && in_ready.
  - in_valid while in_ready=0 is held off, not dropped.
- A start pulse while busy is ignored; it does not set err.
- rst mid-load: the load aborts immediately, outputs return to reset values, and already-written words remain in SRAM.
- The block never asserts more than one cs_ram bit, and never asserts wr=0 without a cs_ram bit set.

Optional Feature:
- Macro: MSG_RAM_WRITER_VERIFY_EN.
- Defined:
  - After WRITE, enter VERIFY: cs_ram held, wr=1, same address.
  - On the next cycle, compare rd_data[13:0] (extra input rd_data, 16 bits, the muxed SRAM dataout) with the written word.
  - Mismatch sets err=1; the load still continues to completion.
- Not defined: no rd_data port, no VERIFY state; err is raised only by a rejected start.

Decomposition:
- Shared package msg_pkg:
  - Bank codes: BANK_ROM=2'b00, BANK_RAM1=2'b01, BANK_RAM2=2'b10, BANK_RAM3=2'b11.
  - MAX_WORDS, WORD_W.
  - FSM state enum: IDLE, ACCEPT, WRITE, VERIFY, ADV.
  - Function bank_to_cs (2 bits → one-hot 3 bits). The display reader reuses the same function.
- No sub-module; a single FSM with its counters.

Test Plan:
- Normal load: start, base_addr=0x400, word_cnt=6, words 0x1A2B..0x1A30 sent back-to-back → six write cycles with cs_ram=001, wr=0, offsets 0..5, data_in=0x1A2B.. in order; done pulses once; SRAM readback matches.
- Backpressure: in_valid toggles 1,0,0,1 with base_addr=0x800, word_cnt=2 → exactly 2 writes with cs_ram=010; no duplicate or lost word; in_ready is 0 during WRITE and ADV.
- Wrap: base_addr=0xFFF, word_cnt=2 → writes at offsets 1023 then 0, cs_ram=100 on both.
- Reject: base_addr=0x005, word_cnt=3 → err=1, no cs_ram activity. Repeat with word_cnt=7 → err=1. A following valid start → err clears.
- Reset mid-load: rst asserted after the 2nd write of 6 → next cycle busy=0, wr=1, cs_ram=000; SRAM holds only words 0 and 1.
- Verify (macro defined): rd_data forced to 0x0000 for word 3 → err=1, done still pulses after word 6.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared definitions for the message RAM writer and the display reader:
// bank codes, message geometry, FSM state encoding and the bank-to-chip-select
// decode used by both sides of the SRAM.
package msg_pkg;

  localparam int WORD_W    = 14;  // glyph-column payload width
  localparam int DATA_W    = 16;  // SRAM word width
  localparam int ADDR_W    = 12;  // [11:10] bank, [9:0] offset
  localparam int OFF_W     = 10;
  localparam int MAX_WORDS = 6;   // one display frame

  localparam logic [1:0] BANK_ROM  = 2'b00;
  localparam logic [1:0] BANK_RAM1 = 2'b01;
  localparam logic [1:0] BANK_RAM2 = 2'b10;
  localparam logic [1:0] BANK_RAM3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    VERIFY = 3'd3,
    ADV    = 3'd4
  } state_t;

  // ROM has no chip select; RAM banks map to one-hot cs bits 0..2.
  function automatic logic [2:0] bank_to_cs(input logic [1:0] bank);
    logic [2:0] cs;
    case (bank)
      BANK_RAM1: cs = 3'b001;
      BANK_RAM2: cs = 3'b010;
      BANK_RAM3: cs = 3'b100;
      default:   cs = 3'b000;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/msg_ram_writer.sv
// msg_ram_writer: stores a runtime-loaded message (1..MAX_WORDS glyph-column
// words) into consecutive locations of one SRAM bank, so the display reader
// can scroll it in place of the ROM text.
// Optional build macro MSG_RAM_WRITER_VERIFY_EN adds a read-back check of
// every written word through the rd_data port; a mismatch raises err.
// All outputs are registered; each word takes ACCEPT, WRITE, (VERIFY,) ADV.
module msg_ram_writer
  import msg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [2:0]          word_cnt,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OFF_W-1:0]    address,
  output logic [DATA_W-1:0]   data_in,
  output logic [2:0]          cs_ram,
  output logic                wr,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef MSG_RAM_WRITER_VERIFY_EN
  ,
  input  logic [DATA_W-1:0]   rd_data
`endif
);

  state_t             state_q,    state_d;
  logic [1:0]         bank_q,     bank_d;
  logic [OFF_W-1:0]   offset_q,   offset_d;
  logic [2:0]         remain_q,   remain_d;
  logic               in_ready_q, in_ready_d;
  logic [OFF_W-1:0]   address_q,  address_d;
  logic [DATA_W-1:0]  data_q,     data_d;
  logic [2:0]         cs_q,       cs_d;
  logic               wr_q,       wr_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               err_q,      err_d;

`ifdef MSG_RAM_WRITER_VERIFY_EN
  // Only the payload bits are compared; the pad bits are read but unused.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[DATA_W-1:WORD_W];
`endif

  // Next-state and next-output decode; outputs are computed one state ahead
  // so every SRAM control pin comes straight from a flop.
  always_comb begin
    // NOTE: every _d defaults to its _q (done to 0) before the case, so no
    // path through the decode leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    bank_d     = bank_q;
    offset_d   = offset_q;
    remain_d   = remain_q;
    in_ready_d = in_ready_q;
    address_d  = address_q;
    data_d     = data_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (base_addr[ADDR_W-1:OFF_W] == BANK_ROM || word_cnt == 3'd0 ||
              word_cnt > 3'(MAX_WORDS)) begin
            err_d = 1'b1;  // rejected: no SRAM access at all
          end else begin
            bank_d     = base_addr[ADDR_W-1:OFF_W];
            offset_d   = base_addr[OFF_W-1:0];
            remain_d   = word_cnt;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
            state_d    = ACCEPT;
          end
        end
      end

      ACCEPT: begin
        if (in_valid && in_ready_q) begin
          data_d     = {{(DATA_W-WORD_W){1'b0}}, in_data};
          address_d  = offset_q;
          cs_d       = bank_to_cs(bank_q);
          wr_d       = 1'b0;
          in_ready_d = 1'b0;
          state_d    = WRITE;
        end
      end

      WRITE: begin
        wr_d = 1'b1;
`ifdef MSG_RAM_WRITER_VERIFY_EN
        state_d = VERIFY;  // keep cs and address for the read-back cycle
`else
        cs_d    = 3'b000;
        state_d = ADV;
`endif
      end

`ifdef MSG_RAM_WRITER_VERIFY_EN
      VERIFY: begin
        if (rd_data[WORD_W-1:0] != data_q[WORD_W-1:0]) err_d = 1'b1;
        cs_d    = 3'b000;
        state_d = ADV;
      end
`endif

      ADV: begin
        // Offset wraps within the bank; the bank code is never touched.
        offset_d = offset_q + 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == 3'd1) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          in_ready_d = 1'b1;
          state_d    = ACCEPT;
        end
      end

      default: begin
        cs_d       = 3'b000;
        wr_d       = 1'b1;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      bank_q     <= BANK_ROM;
      offset_q   <= '0;
      remain_q   <= '0;
      in_ready_q <= 1'b0;
      address_q  <= '0;
      data_q     <= '0;
      cs_q       <= 3'b000;
      wr_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      offset_q   <= offset_d;
      remain_q   <= remain_d;
      in_ready_q <= in_ready_d;
      address_q  <= address_d;
      data_q     <= data_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign address  = address_q;
  assign data_in  = data_q;
  assign cs_ram   = cs_q;
  assign wr       = wr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
